// File: rtl/timer_tick_sequencer_if.sv
// Avalon-MM write-only bus to the interval timer slave, plus its IRQ line.
interface timer_tick_sequencer_if;
  logic [3:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic        timer_irq;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  timer_irq
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output timer_irq
  );
endinterface

// File: rtl/timer_tick_sequencer.sv
// Programs the interval timer, services its timeout IRQs and emits one
// game tick per timeout. Handles runtime period reload and stop requests.
module timer_tick_sequencer #(
  parameter logic [63:0] DEFAULT_PERIOD = 64'd49999,
  parameter bit          AUTO_START     = 1'b1,
  parameter int          TICK_CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  timer_tick_sequencer_if.master bus,
  input  logic [63:0]           cfg_period,
  input  logic                  cfg_load,
  input  logic                  cfg_stop,
  output logic                  cfg_busy,
  output logic                  running,
  output logic                  tick,
  output logic [TICK_CNT_W-1:0] tick_count,
  output logic                  overrun
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_P0, S_WR_P1, S_WR_P2, S_WR_P3, S_WR_CTRL, S_RUN, S_CLR, S_WR_STOP
  } state_t;

  state_t      state, state_nxt;
  logic [63:0] period, period_d;
  logic        pend_load, pend_stop, post_clr, auto_done;
  logic        take_load, load_acc;
  logic        cs_d;
  logic [3:0]  addr_d;
  logic [15:0] data_d;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state: pending requests from CLR beat fresh ones; stop > load > irq
  always_comb begin
    state_nxt = state;
    take_load = 1'b0;
    load_acc  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (AUTO_START && !auto_done) begin
          state_nxt = S_WR_P0;
        end else if (cfg_load) begin
          state_nxt = S_WR_P0;
          take_load = 1'b1;
          load_acc  = 1'b1;
        end
      end
      S_WR_P0:   state_nxt = S_WR_P1;
      S_WR_P1:   state_nxt = S_WR_P2;
      S_WR_P2:   state_nxt = S_WR_P3;
      S_WR_P3:   state_nxt = S_WR_CTRL;
      S_WR_CTRL: state_nxt = S_RUN;
      S_RUN: begin
        if (pend_stop) begin
          state_nxt = S_WR_STOP;
        end else if (pend_load) begin
          state_nxt = S_WR_P0;
          load_acc  = 1'b1;
        end else if (cfg_stop) begin
          state_nxt = S_WR_STOP;
        end else if (cfg_load) begin
          state_nxt = S_WR_P0;
          take_load = 1'b1;
          load_acc  = 1'b1;
        end else if (bus.timer_irq) begin
          state_nxt = S_CLR;
        end
      end
      S_CLR:     state_nxt = S_RUN;
      S_WR_STOP: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output decode: bus cycle for the state being entered, registered below
  always_comb begin
    period_d = take_load ? cfg_period : period;
    cs_d     = 1'b0;
    addr_d   = 4'd0;
    data_d   = 16'h0000;
    unique case (state_nxt)
      S_WR_P0:   begin cs_d = 1'b1; addr_d = 4'd2; data_d = period_d[15:0];  end
      S_WR_P1:   begin cs_d = 1'b1; addr_d = 4'd3; data_d = period_d[31:16]; end
      S_WR_P2:   begin cs_d = 1'b1; addr_d = 4'd4; data_d = period_d[47:32]; end
      S_WR_P3:   begin cs_d = 1'b1; addr_d = 4'd5; data_d = period_d[63:48]; end
      S_WR_CTRL: begin cs_d = 1'b1; addr_d = 4'd1; data_d = 16'h0007;        end
      S_CLR:     begin cs_d = 1'b1; addr_d = 4'd0; data_d = 16'h0000;        end
      S_WR_STOP: begin cs_d = 1'b1; addr_d = 4'd1; data_d = 16'h0008;        end
      default:   ;
    endcase
  end

  // Registered bus drive, tick pulse and tick counter aligned with the state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.avm_chipselect <= 1'b0;
      bus.avm_write_n    <= 1'b1;
      bus.avm_address    <= 4'd0;
      bus.avm_writedata  <= 16'h0000;
      tick               <= 1'b0;
      tick_count         <= '0;
    end else begin
      bus.avm_chipselect <= cs_d;
      bus.avm_write_n    <= ~cs_d;
      bus.avm_address    <= addr_d;
      bus.avm_writedata  <= data_d;
      tick               <= (state_nxt == S_CLR);
      if (state_nxt == S_WR_CTRL)  tick_count <= '0;
      else if (state_nxt == S_CLR) tick_count <= tick_count + TICK_CNT_W'(1);
    end
  end

  // Period latch, one-deep request holding across CLR, overrun detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period    <= DEFAULT_PERIOD;
      pend_load <= 1'b0;
      pend_stop <= 1'b0;
      post_clr  <= 1'b0;
      auto_done <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      auto_done <= 1'b1;
      post_clr  <= (state == S_CLR);
      pend_stop <= (state == S_CLR) && cfg_stop;
      pend_load <= (state == S_CLR) && cfg_load && !cfg_stop;
      if (take_load)
        period <= cfg_period;
      else if (state == S_CLR && cfg_load && !cfg_stop)
        period <= cfg_period;
      // A restart wins over a same-cycle overrun detection
      if (load_acc)
        overrun <= 1'b0;
      else if (state == S_RUN && post_clr && bus.timer_irq)
        overrun <= 1'b1;
    end
  end

  assign running  = (state == S_RUN) || (state == S_CLR);
  assign cfg_busy = (state == S_WR_P0) || (state == S_WR_P1) || (state == S_WR_P2) ||
                    (state == S_WR_P3) || (state == S_WR_CTRL) || (state == S_WR_STOP);

endmodule
